// File: rtl/mac_feeder.sv
// mac_feeder: collects a 3x3 weight kernel plus an exponent bias, then streams
// a raster-order image and presents every fully populated 3x3 pixel window,
// together with the kernel, to a downstream MAC.
//
// Handshakes (pix_valid/pix_ready and win_valid/win_ready): a transfer occurs
// on a rising clk edge where valid and ready are both high. Once the producer
// raises valid, it keeps valid and its payload stable until that transfer
// happens. pix_ready depends only on state, win_valid and win_ready, never on
// pix_valid.
module mac_feeder #(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wt_load,
   input  logic [3:0]  wt_in,
   input  logic [4:0]  bias_in,
   input  logic        pix_valid,
   output logic        pix_ready,
   input  logic [7:0]  pix_in,
   output logic        win_valid,
   input  logic        win_ready,
   output logic [71:0] image,
   output logic [35:0] weight,
   output logic [4:0]  exp_bias,
   output logic        frame_done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);
   localparam logic [3:0]    NIB_LAST = 4'd8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD_W = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } state_t;

   // FSM state; kept as a plainly named register so checkers can bind to it.
   state_t state;
   state_t state_nxt;

   logic [3:0]    nib_cnt;
   logic [CW-1:0] col;
   logic [RW-1:0] row;

   // Two previous image rows: lb_old holds row-2, lb_new holds row-1.
   logic [7:0] lb_old [IMG_W];
   logic [7:0] lb_new [IMG_W];

   // The two most recent columns of the sliding window, newer column in [7:0].
   logic [15:0] sh_top;
   logic [15:0] sh_mid;
   logic [15:0] sh_bot;

   logic       accept;
   logic       last_pix;
   logic       win_hit;
   logic       load_step;
   logic       load_last;
   logic [7:0] top_px;
   logic [7:0] mid_px;

   // Decode of the current pixel position and handshake events.
   always_comb begin
      accept    = pix_valid && pix_ready;
      last_pix  = (col == COL_LAST) && (row == ROW_LAST);
      win_hit   = accept && (col >= COL_TWO) && (row >= ROW_TWO);
      load_step = wt_load && ((state == IDLE) || (state == LOAD_W));
      load_last = wt_load && (state == LOAD_W) && (nib_cnt == NIB_LAST);
      top_px    = lb_old[col];
      mid_px    = lb_new[col];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and the two state-derived outputs.
   always_comb begin
      state_nxt  = state;
      pix_ready  = 1'b0;
      frame_done = 1'b0;
      unique case (state)
         IDLE: begin
            if (wt_load) begin
               state_nxt = LOAD_W;
            end
         end
         LOAD_W: begin
            if (load_last) begin
               state_nxt = STREAM;
            end
         end
         STREAM: begin
            // A new pixel may enter only if its window (if any) has room.
            pix_ready = !win_valid || win_ready;
            if (pix_valid && (!win_valid || win_ready) && last_pix) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            // Final window gone: announce the end of frame and go idle.
            if (!win_valid) begin
               frame_done = 1'b1;
               state_nxt  = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      // Outputs are quiet for the whole time reset is held.
      if (rst) begin
         pix_ready  = 1'b0;
         frame_done = 1'b0;
      end
   end

   // Weight nibble shifter and bias capture; untouched while streaming.
   always_ff @(posedge clk) begin
      if (rst) begin
         weight   <= '0;
         exp_bias <= '0;
         nib_cnt  <= '0;
      end else if (load_step) begin
         weight <= {weight[31:0], wt_in};
         if (state == IDLE) begin
            nib_cnt <= 4'd1;
         end else begin
            nib_cnt <= nib_cnt + 4'd1;
         end
         if (load_last) begin
            exp_bias <= bias_in;
         end
      end
   end

   // Column/row position of the next pixel to be accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if ((state == DONE) && !win_valid) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (col == COL_LAST) begin
            col <= '0;
            if (row == ROW_LAST) begin
               row <= '0;
            end else begin
               row <= row + RW'(1);
            end
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   // Line buffers and window columns; every row is rewritten before use, so
   // these carry no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb_old[col] <= mid_px;
         lb_new[col] <= pix_in;
         sh_top      <= {sh_top[7:0], top_px};
         sh_mid      <= {sh_mid[7:0], mid_px};
         sh_bot      <= {sh_bot[7:0], pix_in};
      end
   end

   // Output window register: load on a qualifying accept, drop on consume.
   always_ff @(posedge clk) begin
      if (rst) begin
         image     <= '0;
         win_valid <= 1'b0;
      end else if (win_hit) begin
         image     <= {sh_top, top_px, sh_mid, mid_px, sh_bot, pix_in};
         win_valid <= 1'b1;
      end else if (win_ready) begin
         win_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder on an 8x8 frame whose pixel value is
// row*8+col: weight loading table, window spot-check table, back-pressure,
// reset mid-frame and a frame with random valid/ready gaps.
module tb_mac_feeder;

   localparam int W = 8;
   localparam int H = 8;
   localparam int NPIX = W * H;
   localparam int NWIN = (W - 2) * (H - 2);

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wt_load = 1'b0;
   logic [3:0]  wt_in = '0;
   logic [4:0]  bias_in = '0;
   logic        pix_valid = 1'b0;
   logic        pix_ready;
   logic [7:0]  pix_in = '0;
   logic        win_valid;
   logic        win_ready = 1'b0;
   logic [71:0] image;
   logic [35:0] weight;
   logic [4:0]  exp_bias;
   logic        frame_done;

   int n_tests = 0;
   int n_fail  = 0;

   logic [71:0] exp_q [$];
   logic [71:0] got_q [$];
   int          fd_cnt = 0;
   bit          mon_en = 1'b0;
   bit          prev_stall = 1'b0;
   logic [71:0] prev_img = '0;

   typedef struct {
      logic [3:0]  nib;
      logic [4:0]  bias;
      logic [35:0] exp_w;
      logic        exp_rdy;
   } ld_vec_t;

   typedef struct {
      int          idx;
      logic [71:0] img;
   } win_vec_t;

   ld_vec_t  ld_tab [9];
   win_vec_t win_tab [4];

   mac_feeder #(.IMG_W(W), .IMG_H(H)) dut (
      .clk        (clk),
      .rst        (rst),
      .wt_load    (wt_load),
      .wt_in      (wt_in),
      .bias_in    (bias_in),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_in     (pix_in),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .image      (image),
      .weight     (weight),
      .exp_bias   (exp_bias),
      .frame_done (frame_done)
   );

   // Clock.
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] pix(input int r, input int c);
      return 8'(r * W + c);
   endfunction

   // Monitor: frame_done pulses, stall stability and consumed windows.
   always @(negedge clk) begin
      if (frame_done) fd_cnt++;
      if (prev_stall && !rst) begin
         check("hold_valid", {71'b0, win_valid}, 72'd1);
         check("hold_image", image, prev_img);
      end
      prev_stall = win_valid && !win_ready && !rst;
      prev_img   = image;
      if (mon_en && win_valid && win_ready) got_q.push_back(image);
   end

   task automatic load_weights(input logic [35:0] nibs, input logic [4:0] bias, input bit gaps);
      for (int k = 0; k < 9; k++) begin
         if (gaps) begin
            wt_load = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
         end
         wt_load = 1'b1;
         wt_in   = nibs[35 - 4 * k -: 4];
         bias_in = (k == 8) ? bias : 5'($urandom_range(0, 31));
         tick();
      end
      wt_load = 1'b0;
   endtask

   // Drive a full frame; mode 0 = always valid/ready, 1 = one 5-cycle stall,
   // 2 = random pix_valid gaps and random win_ready.
   task automatic run_frame(input int mode, input string tag);
      int idx = 0;
      int budget = 0;
      bit lat_armed = 1'b0;
      int stall_left = 0;
      bit stall_done = 1'b0;
      got_q.delete();
      fd_cnt = 0;
      mon_en = 1'b1;
      while (fd_cnt == 0 && budget < 3000) begin
         pix_valid = (idx < NPIX) && ((mode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1);
         pix_in    = 8'(idx);
         if (mode == 1 && !stall_done && got_q.size() == 3 && win_valid) begin
            stall_left = 5;
            stall_done = 1'b1;
         end
         if (stall_left > 0) begin
            win_ready = 1'b0;
            stall_left--;
         end else begin
            win_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         @(negedge clk);
         if (win_valid && !win_ready) check({tag, "_stall_pix_ready"}, {71'b0, pix_ready}, 72'd0);
         if (lat_armed) begin
            check("first_win_valid", {71'b0, win_valid}, 72'd1);
            check("first_win_image", image, 72'h000102_08090A_101112);
            lat_armed = 1'b0;
         end
         if (pix_valid && pix_ready) begin
            if (mode == 0 && idx == 18) begin
               check("pre_first_valid", {71'b0, win_valid}, 72'd0);
               lat_armed = 1'b1;
            end
            idx++;
         end
         tick();
         budget++;
      end
      pix_valid = 1'b0;
      win_ready = 1'b0;
      mon_en    = 1'b0;
      if (budget >= 3000) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: got no frame_done within %0d cycles", tag, budget);
      end
      repeat (3) tick();
      check({tag, "_pixels"}, 72'(idx), 72'(NPIX));
      check({tag, "_win_count"}, 72'(got_q.size()), 72'(NWIN));
      for (int i = 0; i < NWIN && i < got_q.size(); i++) begin
         check({tag, "_win_seq"}, got_q[i], exp_q[i]);
      end
      check({tag, "_frame_done_cnt"}, 72'(fd_cnt), 72'd1);
      @(negedge clk);
      check({tag, "_idle_pix_ready"}, {71'b0, pix_ready}, 72'd0);
      tick();
   endtask

   initial begin
      int refused;
      int idx;
      int budget;

      // Reference window sequence from the pixel formula.
      for (int r = 2; r < H; r++) begin
         for (int c = 2; c < W; c++) begin
            exp_q.push_back({pix(r-2, c-2), pix(r-2, c-1), pix(r-2, c),
                             pix(r-1, c-2), pix(r-1, c-1), pix(r-1, c),
                             pix(r,   c-2), pix(r,   c-1), pix(r,   c)});
         end
      end

      ld_tab[0] = '{4'h1, 5'd3,  36'h000000001, 1'b0};
      ld_tab[1] = '{4'h2, 5'd0,  36'h000000012, 1'b0};
      ld_tab[2] = '{4'h3, 5'd7,  36'h000000123, 1'b0};
      ld_tab[3] = '{4'h4, 5'd1,  36'h000001234, 1'b0};
      ld_tab[4] = '{4'h5, 5'd31, 36'h000012345, 1'b0};
      ld_tab[5] = '{4'h6, 5'd2,  36'h000123456, 1'b0};
      ld_tab[6] = '{4'h7, 5'd9,  36'h001234567, 1'b0};
      ld_tab[7] = '{4'h8, 5'd4,  36'h012345678, 1'b0};
      ld_tab[8] = '{4'h9, 5'd15, 36'h123456789, 1'b1};

      win_tab[0] = '{0,  72'h000102_08090A_101112};
      win_tab[1] = '{5,  72'h050607_0D0E0F_151617};
      win_tab[2] = '{6,  72'h08090A_101112_18191A};
      win_tab[3] = '{35, 72'h2D2E2F_353637_3D3E3F};

      // Reset held for two cycles.
      rst = 1'b1;
      repeat (2) tick();
      @(negedge clk);
      check("rst_image", image, 72'd0);
      check("rst_weight", 72'(weight), 72'd0);
      check("rst_exp_bias", 72'(exp_bias), 72'd0);
      check("rst_win_valid", {71'b0, win_valid}, 72'd0);
      check("rst_pix_ready", {71'b0, pix_ready}, 72'd0);
      check("rst_frame_done", {71'b0, frame_done}, 72'd0);
      tick();
      rst = 1'b0;

      // Weight load, one table row per nibble.
      for (int k = 0; k < 9; k++) begin
         wt_load = 1'b1;
         wt_in   = ld_tab[k].nib;
         bias_in = ld_tab[k].bias;
         tick();
         @(negedge clk);
         check("load_weight", 72'(weight), 72'(ld_tab[k].exp_w));
         check("load_pix_ready", {71'b0, pix_ready}, {71'b0, ld_tab[k].exp_rdy});
      end
      wt_load = 1'b0;
      check("load_exp_bias", 72'(exp_bias), 72'd15);
      tick();

      // Directed frame, then window spot checks.
      run_frame(0, "directed");
      for (int i = 0; i < 4; i++) begin
         if (win_tab[i].idx < got_q.size())
            check("win_table", got_q[win_tab[i].idx], win_tab[i].img);
         else
            check("win_table_missing", 72'(got_q.size()), 72'(win_tab[i].idx + 1));
      end
      check("retain_weight", 72'(weight), 72'h123456789);
      check("retain_exp_bias", 72'(exp_bias), 72'd15);

      // Wt_load attempt while streaming must not disturb the kernel; then stall frame.
      load_weights(36'h123456789, 5'd15, 1'b0);
      wt_load = 1'b1;
      wt_in   = 4'hF;
      tick();
      wt_load = 1'b0;
      @(negedge clk);
      check("stream_wt_ignored", 72'(weight), 72'h123456789);
      tick();
      run_frame(1, "stall");

      // Reset after 20 accepted pixels.
      load_weights(36'h123456789, 5'd15, 1'b0);
      idx = 0;
      budget = 0;
      while (idx < 20 && budget < 200) begin
         pix_valid = 1'b1;
         pix_in    = 8'(idx);
         win_ready = 1'b1;
         @(negedge clk);
         if (pix_ready) idx++;
         tick();
         budget++;
      end
      check("pre_reset_pixels", 72'(idx), 72'd20);
      rst = 1'b1;
      tick();
      @(negedge clk);
      check("mid_rst_image", image, 72'd0);
      check("mid_rst_weight", 72'(weight), 72'd0);
      check("mid_rst_exp_bias", 72'(exp_bias), 72'd0);
      check("mid_rst_win_valid", {71'b0, win_valid}, 72'd0);
      check("mid_rst_pix_ready", {71'b0, pix_ready}, 72'd0);
      tick();
      rst = 1'b0;
      refused = 0;
      for (int k = 0; k < 10; k++) begin
         pix_valid = 1'b1;
         @(negedge clk);
         if (!pix_ready && !win_valid) refused++;
         tick();
      end
      pix_valid = 1'b0;
      check("post_rst_refused", 72'(refused), 72'd10);

      // Fresh load with gaps, then a frame with random gaps on both sides.
      load_weights(36'hABCDEF012, 5'd7, 1'b1);
      @(negedge clk);
      check("reload_weight", 72'(weight), 72'hABCDEF012);
      check("reload_exp_bias", 72'(exp_bias), 72'd7);
      check("reload_pix_ready", {71'b0, pix_ready}, 72'd1);
      tick();
      run_frame(2, "random");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
